// File: rtl/pcie_ss_rd_tag_tracker.sv
// pcie_ss_rd_tag_tracker
//   Passive read-tag tracker that sits beside the PCIe SS TX arbiter and the RX
//   completion demux. It records every DM memory read by tag, retires tags as
//   their completions return, flags protocol faults, and hands freed tags back
//   to the requester's tag pool.
//
//   Optional feature macro: PCIE_TAG_TRACKER_TIMEOUT_EN
//     defined   : round-robin timeout scanner, issue timestamps, free-running now
//     undefined : no scanner, no timestamps, timeout_err tied low
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/sop/is_mrd      TX request handshake and header qualifiers
//   req_tag, req_len                decoded read tag and requested byte count
//   cpl_valid/ready/sop/is_cpl      RX completion handshake and header qualifiers
//   cpl_tag, cpl_len                decoded completion tag and payload bytes
//   tag_free_valid, tag_free        one-cycle pulse returning a retired tag
//   outstanding                     number of live tags
//   reuse/unexp/overrun/timeout_err one-cycle error pulses
//   err_tag                         tag of the most recent error
module pcie_ss_rd_tag_tracker #(
    parameter int TAG_W       = 10,
    parameter int LEN_W       = 24,
    parameter int TS_W        = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_ready,
    input  logic             req_sop,
    input  logic             req_is_mrd,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [LEN_W-1:0] req_len,
    input  logic             cpl_valid,
    input  logic             cpl_ready,
    input  logic             cpl_sop,
    input  logic             cpl_is_cpl,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [LEN_W-1:0] cpl_len,
    output logic             tag_free_valid,
    output logic [TAG_W-1:0] tag_free,
    output logic [TAG_W:0]   outstanding,
    output logic             reuse_err,
    output logic             unexp_err,
    output logic             overrun_err,
    output logic             timeout_err,
    output logic [TAG_W-1:0] err_tag
);

    localparam int NUM_TAGS = 1 << TAG_W;

    // The timestamp arithmetic is modulo 2**TS_W, so a longer timeout would alias.
    if (TIMEOUT_CYC >= (1 << TS_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be below 2**TS_W");
    end

    logic [NUM_TAGS-1:0] live;
    logic [LEN_W-1:0]    remaining [NUM_TAGS];

    logic             iss, cmp;
    logic [LEN_W-1:0] req_len_eff, cpl_rem;
    logic             cpl_hit, cpl_retire, over_hit, unexp_hit;
    logic             req_live_post, reuse_hit;
    logic             to_hit;
    logic [TAG_W-1:0] to_tag;
    logic             pend_valid;
    logic [TAG_W-1:0] pend_tag;

    assign iss         = req_valid & req_ready & req_sop & req_is_mrd;
    assign cmp         = cpl_valid & cpl_ready & cpl_sop & cpl_is_cpl;
    assign req_len_eff = (req_len == '0) ? LEN_W'(1) : req_len;

    // Completion is resolved first; the issue sees the post-completion live bit.
    assign cpl_rem       = remaining[cpl_tag];
    assign unexp_hit     = cmp & ~live[cpl_tag];
    assign cpl_hit       = cmp & live[cpl_tag];
    assign over_hit      = cpl_hit & (cpl_len > cpl_rem);
    assign cpl_retire    = cpl_hit & (cpl_len >= cpl_rem);
    assign req_live_post = live[req_tag] & ~(cpl_retire & (cpl_tag == req_tag));
    assign reuse_hit     = iss & req_live_post;

`ifdef PCIE_TAG_TRACKER_TIMEOUT_EN
    logic [TS_W-1:0]  now;
    logic [TS_W-1:0]  ts [NUM_TAGS];
    logic [TAG_W-1:0] scan_ptr;
    logic [TS_W-1:0]  age;

    assign age    = now - ts[scan_ptr];
    assign to_tag = scan_ptr;
    // Scanning is frozen while a timeout retire waits for the tag_free port, and
    // a hit on a tag being touched this cycle is dropped to avoid racing it.
    assign to_hit = ~pend_valid & live[scan_ptr] & (age >= TS_W'(TIMEOUT_CYC))
                  & ~(iss & (req_tag == scan_ptr))
                  & ~(cmp & (cpl_tag == scan_ptr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now        <= '0;
            scan_ptr   <= '0;
            pend_valid <= 1'b0;
            pend_tag   <= '0;
        end else begin
            now <= now + TS_W'(1);
            if (!pend_valid) scan_ptr <= scan_ptr + TAG_W'(1);
            if (cpl_retire && to_hit) begin
                pend_valid <= 1'b1;
                pend_tag   <= to_tag;
            end else if (!cpl_retire && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (iss) ts[req_tag] <= now;
    end
`else
    assign to_hit     = 1'b0;
    assign to_tag     = '0;
    assign pend_valid = 1'b0;
    assign pend_tag   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= '0;
        end else begin
            // NOTE: later non-blocking writes win, so an issue re-arms a tag that a
            // completion retires in the same cycle.
            if (cpl_retire) live[cpl_tag] <= 1'b0;
            if (to_hit)     live[to_tag]  <= 1'b0;
            if (iss)        live[req_tag] <= 1'b1;
        end
    end

    // NOTE: the byte table is deliberately not reset; an entry's contents are
    // only ever read while its live bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        if (cpl_hit && !cpl_retire) remaining[cpl_tag] <= cpl_rem - cpl_len;
        if (iss)                    remaining[req_tag] <= req_len_eff;
    end

    // Live count: at most one new tag and up to two retires (completion + timeout).
    logic [TAG_W+1:0] cnt_up, cnt_dn, cnt_next;
    always_comb begin
        cnt_up   = {1'b0, outstanding} + (TAG_W+2)'(iss & ~req_live_post);
        cnt_dn   = (TAG_W+2)'(cpl_retire) + (TAG_W+2)'(to_hit);
        cnt_next = (cnt_up < cnt_dn) ? '0 : cnt_up - cnt_dn;
        if (cnt_next > (TAG_W+2)'(NUM_TAGS)) cnt_next = (TAG_W+2)'(NUM_TAGS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_free_valid <= 1'b0;
            tag_free       <= '0;
            outstanding    <= '0;
            reuse_err      <= 1'b0;
            unexp_err      <= 1'b0;
            overrun_err    <= 1'b0;
            timeout_err    <= 1'b0;
            err_tag        <= '0;
        end else begin
            reuse_err   <= reuse_hit;
            unexp_err   <= unexp_hit;
            overrun_err <= over_hit;
            timeout_err <= to_hit;
            outstanding <= cnt_next[TAG_W:0];

            if (to_hit)                      err_tag <= to_tag;
            else if (over_hit || unexp_hit)  err_tag <= cpl_tag;
            else if (reuse_hit)              err_tag <= req_tag;

            // Completion retire owns the port; a held timeout retire goes next.
            tag_free_valid <= cpl_retire | pend_valid | to_hit;
            if (cpl_retire)      tag_free <= cpl_tag;
            else if (pend_valid) tag_free <= pend_tag;
            else if (to_hit)     tag_free <= to_tag;
        end
    end

endmodule
